jtbubl_sndcomm: RTL

JTBUBL_SNDCOMM -- requirements
Module: jtbubl_sndcomm

---
 rtl/jtbubl_sndcomm_pkg.sv | 19 +
 rtl/jtbubl_sndcomm_edge.sv | 32 +++
 rtl/jtbubl_sndcomm.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/jtbubl_sndcomm_pkg.sv
// Shared constants for the Bubble Bobble main/sound communication block:
// comm window base and the per-offset register codes.
package jtbubl_sndcomm_pkg;

    localparam logic [7:0] COMM_BASE   = 8'hB0;

    localparam logic [1:0] OFS_LATCH   = 2'd0;
    localparam logic [1:0] OFS_STATUS  = 2'd1;
    localparam logic [1:0] OFS_NMI_ON  = 2'd1;
    localparam logic [1:0] OFS_NMI_OFF = 2'd2;

    localparam logic [7:0] OPEN_BUS    = 8'hff;

    // Unused status bits read back as ones, like an undriven bus.
    function automatic logic [7:0] status_byte(input logic main_pend, input logic snd_flag);
        return {6'h3f, main_pend, snd_flag};
    endfunction

endpackage

// File: rtl/jtbubl_sndcomm_edge.sv
// Registered edge detector: rise/fall pulses are one cycle wide and appear
// one cycle after the input transition is sampled.
module jtbubl_sndcomm_edge #(
    parameter logic IDLE = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic r_prev;
    logic r_rise;
    logic r_fall;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev <= IDLE;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_prev <= i_sig;
            r_rise <= i_sig & ~r_prev;
            r_fall <= ~i_sig & r_prev;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/jtbubl_sndcomm.sv
// Main-to-sound and sound-to-main byte mailbox with status flags and a
// maskable sound-CPU NMI, mapped at 0xB000-0xB0FF of the sound CPU.
module jtbubl_sndcomm (
    input  logic        clk24,
    input  logic        rst,
    input  logic [7:0]  snd_latch,
    input  logic        snd_stb,
    input  logic        snd_rstn,
    input  logic [15:0] snd_addr,
    input  logic        snd_mreq_n,
    input  logic        snd_rd_n,
    input  logic        snd_wr_n,
    input  logic [7:0]  snd_dout,
    output logic        comm_cs,
    output logic [7:0]  comm_dout,
    output logic [7:0]  main_latch,
    output logic        main_stb,
    output logic        snd_flag,
    output logic        snd_nmi_n
);

    import jtbubl_sndcomm_pkg::*;

    logic       w_stb_rise;
    logic       w_rd_fall;
    logic       w_wr_fall;
    logic       w_unused_stb_fall;
    logic       w_unused_rd_rise;
    logic       w_unused_wr_rise;
    logic       w_unused_addr;
    logic       w_comm_cs;
    logic [1:0] w_ofs;
    logic       w_rd_clr;
    logic       w_wr_act;
    logic [7:0] w_rd_mux;

    logic [7:0] r_main_byte;
    logic [7:0] r_main_latch;
    logic       r_main_stb;
    logic       r_snd_flag;
    logic       r_main_pend;
    logic       r_nmi_en;
    logic       r_nmi_pend;
    logic       r_nmi_n;
    logic [7:0] r_comm_dout;

    jtbubl_sndcomm_edge #(.IDLE(1'b0)) u_stb_edge (
        .i_clk  (clk24),
        .i_rst  (rst),
        .i_sig  (snd_stb),
        .o_rise (w_stb_rise),
        .o_fall (w_unused_stb_fall)
    );

    jtbubl_sndcomm_edge #(.IDLE(1'b1)) u_rd_edge (
        .i_clk  (clk24),
        .i_rst  (rst),
        .i_sig  (snd_rd_n),
        .o_rise (w_unused_rd_rise),
        .o_fall (w_rd_fall)
    );

    jtbubl_sndcomm_edge #(.IDLE(1'b1)) u_wr_edge (
        .i_clk  (clk24),
        .i_rst  (rst),
        .i_sig  (snd_wr_n),
        .o_rise (w_unused_wr_rise),
        .o_fall (w_wr_fall)
    );

    assign w_unused_addr = ^snd_addr[7:2];
    assign w_comm_cs     = ~snd_mreq_n & (snd_addr[15:8] == COMM_BASE);
    assign w_ofs         = snd_addr[1:0];
    // Bus edges act at the cycle after detection, qualified by the current address.
    assign w_rd_clr      = w_rd_fall & w_comm_cs & (w_ofs == OFS_LATCH) & snd_rstn;
    assign w_wr_act      = w_wr_fall & w_comm_cs & snd_rstn;

    always_comb begin
        w_rd_mux = OPEN_BUS;
        case (w_ofs)
            OFS_LATCH:  w_rd_mux = r_main_byte;
            OFS_STATUS: w_rd_mux = status_byte(r_main_pend, r_snd_flag);
            default:    w_rd_mux = OPEN_BUS;
        endcase
    end

    always_ff @(posedge clk24) begin
        if (rst) begin
            r_main_byte  <= '0;
            r_main_latch <= '0;
            r_main_stb   <= 1'b0;
            r_snd_flag   <= 1'b0;
            r_main_pend  <= 1'b0;
            r_nmi_en     <= 1'b0;
            r_nmi_pend   <= 1'b0;
            r_nmi_n      <= 1'b1;
            r_comm_dout  <= OPEN_BUS;
        end else begin
            // A new main byte beats a simultaneous acknowledge read.
            if (w_stb_rise) begin
                r_main_byte <= snd_latch;
                r_snd_flag  <= 1'b1;
                r_nmi_pend  <= 1'b1;
            end else if (w_rd_clr) begin
                r_snd_flag  <= 1'b0;
                r_nmi_pend  <= 1'b0;
            end

            r_comm_dout <= snd_rstn ? w_rd_mux : OPEN_BUS;

            if (!snd_rstn) begin
                r_nmi_en    <= 1'b0;
                r_main_pend <= 1'b0;
                r_main_stb  <= 1'b0;
                r_nmi_n     <= 1'b1;
            end else begin
                r_main_stb <= w_wr_act && (w_ofs == OFS_LATCH);
                if (w_wr_act && (w_ofs == OFS_LATCH))
                    r_main_latch <= snd_dout;

                if (w_wr_act && (w_ofs == OFS_NMI_ON))
                    r_nmi_en <= 1'b1;
                else if (w_wr_act && (w_ofs == OFS_NMI_OFF))
                    r_nmi_en <= 1'b0;

                if (r_main_stb)
                    r_main_pend <= 1'b1;
                else if (w_stb_rise)
                    r_main_pend <= 1'b0;

                r_nmi_n <= ~(r_nmi_en & r_nmi_pend);
            end
        end
    end

    assign comm_cs    = w_comm_cs;
    assign comm_dout  = r_comm_dout;
    assign main_latch = r_main_latch;
    assign main_stb   = r_main_stb;
    assign snd_flag   = r_snd_flag;
    assign snd_nmi_n  = r_nmi_n;

endmodule
